// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one tx_uart between N_REQ byte sources, paced by an internal frame timer.
// Optional burst lock (lock[owner] keeps the grant) is enabled with `define TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned GAP_BITS   = 1,
    localparam int unsigned OW        = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] data_in,
    input  logic [N_REQ-1:0]   lock,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         tx_data,
    output logic               tx_ready,
    output logic               busy,
    output logic [OW-1:0]      owner
);

    localparam int unsigned BIT_CYC   = CLK_FREQ / BAUD;
    localparam int unsigned FRAME_CYC = FRAME_BITS * BIT_CYC;
    localparam int unsigned GAP_CYC   = GAP_BITS * BIT_CYC;
    localparam int unsigned MAX_CYC   = (FRAME_CYC > GAP_CYC) ? FRAME_CYC : GAP_CYC;
    localparam int unsigned TW        = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned FRAME_LD  = (FRAME_CYC > 0) ? FRAME_CYC - 1 : 0;
    localparam int unsigned GAP_LD    = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [OW-1:0]      rr_q, rr_d;
    logic [OW-1:0]      owner_d;
    logic [7:0]         tx_data_d;
    logic [N_REQ-1:0]   grant_d;
    logic               tx_ready_d;
    logic               busy_d;

    logic               sel_valid;
    logic [OW-1:0]      sel_idx;
    logic [7:0]         sel_byte;
    logic [OW-1:0]      cand;

    // Winner selection: first requester upward from rr+1, wrapping modulo N_REQ.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
`ifdef TX_ARB_LOCK_EN
        if (lock[owner] && req[owner]) begin
            sel_valid = 1'b1;
            sel_idx   = owner;
        end
`endif
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = OW'((int'(rr_q) + k) % int'(N_REQ));
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

`ifndef TX_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Byte slice of the selected requester.
    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (sel_idx == OW'(i)) begin
                sel_byte = data_in[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic; grant/strobe are set on the transition into LOAD.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rr_d       = rr_q;
        owner_d    = owner;
        tx_data_d  = tx_data;
        grant_d    = '0;
        tx_ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    owner_d    = sel_idx;
                    rr_d       = sel_idx;
                    tx_data_d  = sel_byte;
                    grant_d    = N_REQ'(1) << sel_idx;
                    tx_ready_d = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                timer_d = TW'(FRAME_LD);
                state_d = SEND;
            end
            SEND: begin
                if (timer_q == '0) begin
                    if (GAP_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = TW'(GAP_LD);
                        state_d = GAP;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            rr_q     <= OW'(N_REQ - 1);
            owner    <= '0;
            tx_data  <= 8'h00;
            grant    <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            rr_q     <= rr_d;
            owner    <= owner_d;
            tx_data  <= tx_data_d;
            grant    <= grant_d;
            tx_ready <= tx_ready_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single tx_uart transmitter between N_REQ byte sources, e.g. ctrl_uart echo, status reporter and debug dumper.
- Round-robin arbitration, one byte per grant.
- Drives tx_uart's tx_data/tx_ready start strobe.
- Paces transmissions with an internal frame timer, because tx_uart exposes no busy flag.
- Sits between the requesters and tx_uart inside top-level UART designs.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLK_FREQ, 50000000, clock frequency in Hz
BAUD, 9600, line baud rate; BIT_CYC = CLK_FREQ/BAUD (integer division, must be >= 2)
FRAME_BITS, 10, bit times per frame (start + 8 data + stop)
GAP_BITS, 1, idle bit times inserted after each frame

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester level request; bit i high = byte waiting on data_in slice i
data_in  in  8*N_REQ  requester i byte at [8*i+7:8*i]; held stable while req[i] is high and not yet granted
lock  in  N_REQ  per-requester burst lock; used only with TX_ARB_LOCK_EN
grant  out  N_REQ  one-hot, one-cycle pulse: byte of requester i accepted
tx_data  out  8  byte to tx_uart
tx_ready  out  1  one-cycle start strobe to tx_uart
busy  out  1  high in LOAD, SEND, GAP
owner  out  max(1,clog2(N_REQ))  index of last granted requester

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; tx_data=8'h00; tx_ready=0; grant=0; busy=0; owner=0; rr pointer=N_REQ-1, so req[0] has first priority; timer=0.
- Reset mid-transfer aborts immediately: no further strobe or grant. tx_uart shares rst.
- States: IDLE -> LOAD -> SEND -> GAP -> IDLE.
- IDLE:
  - If req != 0, pick the first set bit searching upward from rr+1, modulo N_REQ.
  - Latch its data_in slice into tx_data; owner and rr <= winner; go to LOAD.
  - Else stay in IDLE.
- LOAD (exactly 1 cycle):
  - tx_ready=1 and grant[owner]=1 in this same cycle.
  - Timer loads FRAME_BITS*BIT_CYC-1; go to SEND.
  - Grant is issued even if req[owner] dropped after selection; the byte was already captured.
- SEND: timer decrements each cycle; at 0, load GAP_BITS*BIT_CYC-1 and go to GAP. If GAP_BITS=0, go directly to IDLE.
- GAP: timer decrements; at 0 go to IDLE.
- Timing:
  - Latency: req sampled high in IDLE at edge k -> tx_ready and grant high during cycle k+1.
  - Back-to-back strobe spacing = 2 + (FRAME_BITS+GAP_BITS)*BIT_CYC cycles.
- tx_data stays constant from LOAD until the next IDLE selection.
- Requester rule: after its grant pulse, a requester either drops req or presents its next byte in the next cycle. Sampling happens only in IDLE.
- req changes during SEND/GAP are ignored until IDLE.
- Simultaneous requests: strict round-robin. No requester is granted twice while another continuously requesting requester waits.
- tx_ready and grant are never high outside LOAD; grant is always one-hot or zero.

Optional Feature:
- Macro: TX_ARB_LOCK_EN.
- Defined:
  - On entering IDLE, if lock[owner] and req[owner] are both high, owner wins again regardless of rotation; rr unchanged.
  - This allows multi-byte packets without interleaving.
  - When the lock drops, rotation resumes from owner+1.
- Undefined: the lock port is ignored (unused input); pure round-robin.

Test Plan:
- Bench setup for all scenarios: CLK_FREQ=1000, BAUD=100 (BIT_CYC=10), N_REQ=4, FRAME_BITS=10, GAP_BITS=1.
- Reset release, req=0 -> tx_ready, grant, busy stay 0 for 500 cycles; tx_data=8'h00; owner=0.
- Single request: req=4'b0100, data slice2=8'hA5 at edge k -> cycle k+1: tx_ready=1, grant=4'b0100, tx_data=8'hA5, owner=2. busy stays high 111 cycles, then low.
- Contention: req=4'b1111 held continuously, distinct bytes per requester -> grants in order 0,1,2,3,0. tx_ready pulses exactly 112 cycles apart. tx_data matches each winner's byte.
- Rotation skip: owner=1 pending; req=4'b1001 -> next grant goes to 3, then 0.
- Reset mid-SEND: assert rst low 50 cycles after a strobe -> outputs return to reset values immediately. After release with req=4'b0001, first grant goes to requester 0.
- With TX_ARB_LOCK_EN: req=4'b0011, lock[0]=1 for 3 grants -> grants 0,0,0. After lock[0]=0 -> grant 1 next. Without the macro -> grants 0,1,0,1.
